// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the two-requester DDR write arbiter: FSM encoding,
// requester count and default AXI widths.
package ddr_arb_pkg;

   localparam int NUM_REQ    = 2;
   localparam int DEF_ADDR_W = 28;
   localparam int DEF_DATA_W = 256;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_WD   = 2'd2
   } arb_state_t;

endpackage

// File: rtl/ddr_wr_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request always wins, a tie goes to the
// requester that was not granted last (last = index of the previous winner).
module rr_arb2
   import ddr_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last,
   output logic [NUM_REQ-1:0] grant
);

   always_comb begin
      grant = '0;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last ? 2'b01 : 2'b10;
         default: grant = '0;
      endcase
   end

endmodule

// File: rtl/ddr_wr_arbiter.sv
// Round-robin arbiter muxing two AXI-style write requesters onto one DDR port.
// Optional burst watchdog enabled by defining DDR_WR_ARB_WDOG_EN.
module ddr_wr_arbiter
   import ddr_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int WDOG_LIMIT = 4096
) (
   input  logic                ddr_clk,
   input  logic                ddr_rst,
   input  logic                arb_en,

   input  logic [ADDR_W-1:0]   m0_awaddr,
   input  logic [3:0]          m0_awlen,
   input  logic                m0_awvalid,
   output logic                m0_awready,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wstrb,
   output logic                m0_wready,
   output logic                m0_wlast,

   input  logic [ADDR_W-1:0]   m1_awaddr,
   input  logic [3:0]          m1_awlen,
   input  logic                m1_awvalid,
   output logic                m1_awready,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wstrb,
   output logic                m1_wready,
   output logic                m1_wlast,

   output logic [ADDR_W-1:0]   ddr_axi_awaddr,
   output logic [3:0]          ddr_axi_awuser_id,
   output logic [3:0]          ddr_axi_awlen,
   output logic                ddr_axi_awvalid,
   input  logic                ddr_axi_awready,
   output logic [DATA_W-1:0]   ddr_axi_wdata,
   output logic [DATA_W/8-1:0] ddr_axi_wstrb,
   input  logic                ddr_axi_wready,
   input  logic                ddr_axi_wusero_last,

   output logic                arb_busy,
   output logic [1:0]          arb_grant,
   output logic                wdog_err,
   input  logic                wdog_clr,
   output arb_state_t          arb_state
);

   // Handshake: a transfer happens on any edge where valid and ready are both 1;
   // valid and its payload hold stable until that edge, ready may toggle freely.

   arb_state_t         state;
   arb_state_t         next_state;
   logic [NUM_REQ-1:0] req_vec;
   logic [NUM_REQ-1:0] rr_gnt;
   logic               last_ptr;
   logic               wd_done;
   logic               wdog_to;

   assign req_vec = {m1_awvalid, m0_awvalid};
   assign wd_done = ddr_axi_wready & ddr_axi_wusero_last;

   rr_arb2 u_rr (
      .req   (req_vec),
      .last  (last_ptr),
      .grant (rr_gnt)
   );

   // State register plus the address/grant payload captured on entry to AW.
   always_ff @(posedge ddr_clk) begin
      if (ddr_rst) begin
         state             <= ST_IDLE;
         ddr_axi_awaddr    <= '0;
         ddr_axi_awlen     <= '0;
         ddr_axi_awuser_id <= '0;
         arb_grant         <= '0;
         last_ptr          <= 1'b1;
      end else begin
         state <= next_state;
         if (state == ST_IDLE && next_state == ST_AW) begin
            arb_grant         <= rr_gnt;
            ddr_axi_awuser_id <= {3'b000, rr_gnt[1]};
            ddr_axi_awaddr    <= rr_gnt[1] ? m1_awaddr : m0_awaddr;
            ddr_axi_awlen     <= rr_gnt[1] ? m1_awlen  : m0_awlen;
         end
         if (state == ST_WD && next_state == ST_IDLE) begin
            arb_grant <= '0;
            last_ptr  <= arb_grant[1];
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (arb_en && (|req_vec)) next_state = ST_AW;
         ST_AW:   if (ddr_axi_awready)      next_state = ST_WD;
         ST_WD:   if (wd_done || wdog_to)   next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      arb_busy        = (state != ST_IDLE);
      ddr_axi_awvalid = (state == ST_AW);
      arb_state       = state;
      m0_awready      = 1'b0;
      m1_awready      = 1'b0;
      m0_wready       = 1'b0;
      m1_wready       = 1'b0;
      m0_wlast        = 1'b0;
      m1_wlast        = 1'b0;
      ddr_axi_wdata   = '0;
      ddr_axi_wstrb   = '0;
      if (state == ST_AW) begin
         m0_awready = ddr_axi_awready & arb_grant[0];
         m1_awready = ddr_axi_awready & arb_grant[1];
      end
      if (state == ST_WD) begin
         m0_wready = ddr_axi_wready      & arb_grant[0];
         m1_wready = ddr_axi_wready      & arb_grant[1];
         m0_wlast  = ddr_axi_wusero_last & arb_grant[0];
         m1_wlast  = ddr_axi_wusero_last & arb_grant[1];
         if (arb_grant[1]) begin
            ddr_axi_wdata = m1_wdata;
            ddr_axi_wstrb = m1_wstrb;
         end else if (arb_grant[0]) begin
            ddr_axi_wdata = m0_wdata;
            ddr_axi_wstrb = m0_wstrb;
         end
      end
   end

`ifdef DDR_WR_ARB_WDOG_EN
   localparam int WDOG_W = $clog2(WDOG_LIMIT + 1);
   logic [WDOG_W-1:0] wdog_cnt;

   // The counter holds the number of beat-less WD cycles already spent.
   assign wdog_to = (state == ST_WD) && !ddr_axi_wready &&
                    (wdog_cnt == WDOG_W'(WDOG_LIMIT - 1));

   always_ff @(posedge ddr_clk) begin
      if (ddr_rst) begin
         wdog_cnt <= '0;
         wdog_err <= 1'b0;
      end else begin
         if (state != ST_WD || ddr_axi_wready || wdog_to) wdog_cnt <= '0;
         else                                              wdog_cnt <= wdog_cnt + 1'b1;
         if (wdog_to)       wdog_err <= 1'b1;
         else if (wdog_clr) wdog_err <= 1'b0;
      end
   end
`else
   logic unused_wdog;
   assign wdog_to     = 1'b0;
   assign wdog_err    = 1'b0;
   assign unused_wdog = &{1'b0, wdog_clr, (WDOG_LIMIT > 0)};
`endif

endmodule

// File: tb/tb_ddr_wr_arbiter.sv
// Self-checking bench for ddr_wr_arbiter: directed scenarios plus randomized
// bursts checked against a round-robin reference model.
module tb_ddr_wr_arbiter;
   import ddr_arb_pkg::*;

   localparam int AW = 28;
   localparam int DW = 256;
   localparam int SW = DW / 8;

   logic          ddr_clk = 1'b0;
   logic          ddr_rst, arb_en;
   logic [AW-1:0] m0_awaddr, m1_awaddr;
   logic [3:0]    m0_awlen, m1_awlen;
   logic          m0_awvalid, m1_awvalid, m0_awready, m1_awready;
   logic [DW-1:0] m0_wdata, m1_wdata;
   logic [SW-1:0] m0_wstrb, m1_wstrb;
   logic          m0_wready, m1_wready, m0_wlast, m1_wlast;
   logic [AW-1:0] ddr_axi_awaddr;
   logic [3:0]    ddr_axi_awuser_id, ddr_axi_awlen;
   logic          ddr_axi_awvalid, ddr_axi_awready;
   logic [DW-1:0] ddr_axi_wdata;
   logic [SW-1:0] ddr_axi_wstrb;
   logic          ddr_axi_wready, ddr_axi_wusero_last;
   logic          arb_busy, wdog_err, wdog_clr;
   logic [1:0]    arb_grant;
   arb_state_t    arb_state;

   int tests_run    = 0;
   int tests_failed = 0;
   int model_last   = 1;

   ddr_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WDOG_LIMIT(16)) dut (
      .ddr_clk(ddr_clk), .ddr_rst(ddr_rst), .arb_en(arb_en),
      .m0_awaddr(m0_awaddr), .m0_awlen(m0_awlen), .m0_awvalid(m0_awvalid), .m0_awready(m0_awready),
      .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready), .m0_wlast(m0_wlast),
      .m1_awaddr(m1_awaddr), .m1_awlen(m1_awlen), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
      .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready), .m1_wlast(m1_wlast),
      .ddr_axi_awaddr(ddr_axi_awaddr), .ddr_axi_awuser_id(ddr_axi_awuser_id),
      .ddr_axi_awlen(ddr_axi_awlen), .ddr_axi_awvalid(ddr_axi_awvalid), .ddr_axi_awready(ddr_axi_awready),
      .ddr_axi_wdata(ddr_axi_wdata), .ddr_axi_wstrb(ddr_axi_wstrb),
      .ddr_axi_wready(ddr_axi_wready), .ddr_axi_wusero_last(ddr_axi_wusero_last),
      .arb_busy(arb_busy), .arb_grant(arb_grant), .wdog_err(wdog_err), .wdog_clr(wdog_clr),
      .arb_state(arb_state)
   );

   // ---------------- clock / global time limit ----------------
   always #5 ddr_clk = ~ddr_clk;

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "time limit");
   end

   // ---------------- reference model ----------------
   // Lone request wins; on a tie the requester not granted last wins.
   function automatic int model_pick(input logic [1:0] req);
      if (req == 2'b11) return 1 - model_last;
      return req[1] ? 1 : 0;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge ddr_clk);
      #1;
   endtask

   task automatic idle_inputs();
      m0_awvalid = 0; m1_awvalid = 0; ddr_axi_awready = 0;
      ddr_axi_wready = 0; ddr_axi_wusero_last = 0; wdog_clr = 0;
   endtask

   task automatic apply_reset();
      ddr_rst = 1; idle_inputs(); arb_en = 1;
      tick(); tick();
      ddr_rst = 0; model_last = 1;
      tick();
   endtask

   // Runs one full burst with the given requesters, returning what was observed.
   task automatic run_burst(input logic [1:0] req, input int aw_wait, input int beats, input bit drop_en,
                            output int lat, output logic [1:0] gnt, output logic [3:0] id,
                            output logic [AW-1:0] addr, output logic [3:0] len, output int unstable,
                            output int awr_cnt, output logic [DW-1:0] wdata, output logic [SW-1:0] wstrb,
                            output logic [1:0] wr_vec, output logic [1:0] wl_vec, output int leak,
                            output logic done, output logic timeout);
      int b, wd_cycles;
      lat = 0; unstable = 0; awr_cnt = 0; leak = 0; done = 0; timeout = 0;
      gnt = 0; id = 0; addr = 0; len = 0; wdata = 0; wstrb = 0; wr_vec = 0; wl_vec = 0;
      m0_awvalid = req[0]; m1_awvalid = req[1]; ddr_axi_awready = 0;
      ddr_axi_wready = 0; ddr_axi_wusero_last = 0;
      @(negedge ddr_clk);
      while (!ddr_axi_awvalid && lat < 8) begin
         tick(); @(negedge ddr_clk); lat++;
      end
      if (!ddr_axi_awvalid) begin
         timeout = 1; idle_inputs(); return;
      end
      gnt = arb_grant; id = ddr_axi_awuser_id; addr = ddr_axi_awaddr; len = ddr_axi_awlen;
      for (int i = 0; i < aw_wait; i++) begin
         awr_cnt += int'(m0_awready) + int'(m1_awready);
         tick(); @(negedge ddr_clk);
         if (!ddr_axi_awvalid || ddr_axi_awaddr !== addr || ddr_axi_awlen !== len ||
             ddr_axi_awuser_id !== id) unstable++;
      end
      ddr_axi_awready = 1; #1;
      awr_cnt += int'(m0_awready) + int'(m1_awready);
      tick();
      ddr_axi_awready = 0; m0_awvalid = 0; m1_awvalid = 0;
      if (drop_en) arb_en = 0;
      b = 0; wd_cycles = 0;
      while (b < beats && wd_cycles < 64) begin
         ddr_axi_wready      = ($urandom_range(0, 3) != 0);
         ddr_axi_wusero_last = ddr_axi_wready && (b == beats - 1);
         #1;
         awr_cnt += int'(m0_awready) + int'(m1_awready);
         if ((!gnt[0] && (m0_wready || m0_wlast)) || (!gnt[1] && (m1_wready || m1_wlast))) leak++;
         if (ddr_axi_wusero_last) begin
            wdata = ddr_axi_wdata; wstrb = ddr_axi_wstrb;
            wr_vec = {m1_wready, m0_wready}; wl_vec = {m1_wlast, m0_wlast};
         end
         if (ddr_axi_wready) b++;
         wd_cycles++;
         tick();
      end
      ddr_axi_wready = 0; ddr_axi_wusero_last = 0;
      if (b < beats) timeout = 1;
      @(negedge ddr_clk);
      done = !arb_busy && (arb_grant == 2'b00);
   endtask

   // ---------------- scenario tasks ----------------
   task automatic test_reset();
      ddr_rst = 1; arb_en = 1; m0_awvalid = 1; m1_awvalid = 1;
      ddr_axi_awready = 1; ddr_axi_wready = 1; ddr_axi_wusero_last = 1; wdog_clr = 0;
      tick(); tick();
      @(negedge ddr_clk);
      tests_run++; if (ddr_axi_awvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_awvalid: got %b want 0", ddr_axi_awvalid); end
      tests_run++; if (arb_grant !== 2'b00) begin tests_failed++; $display("FAIL reset_grant: got %b want 00", arb_grant); end
      tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", arb_busy); end
      tests_run++; if ({ddr_axi_awaddr, ddr_axi_awlen, ddr_axi_awuser_id} !== '0) begin tests_failed++; $display("FAIL reset_aw_payload: got %h/%h/%h want 0", ddr_axi_awaddr, ddr_axi_awlen, ddr_axi_awuser_id); end
      tests_run++; if ({m0_wready, m0_wlast, m1_wready, m1_wlast, m0_awready, m1_awready} !== 6'b0) begin tests_failed++; $display("FAIL reset_gating: got %b want 000000", {m0_wready, m0_wlast, m1_wready, m1_wlast, m0_awready, m1_awready}); end
      tests_run++; if (ddr_axi_wdata !== '0 || ddr_axi_wstrb !== '0) begin tests_failed++; $display("FAIL reset_wdata: got %h want 0", ddr_axi_wdata); end
      tests_run++; if (wdog_err !== 1'b0) begin tests_failed++; $display("FAIL reset_wdog: got %b want 0", wdog_err); end
      idle_inputs();
      tick();
      ddr_rst = 0; model_last = 1;
      tick();
   endtask

   task automatic test_single();
      int lat, unst, awr, leak; logic [1:0] g, wr, wl; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      m0_awaddr = 28'h0000100; m0_awlen = 4'd0;
      m0_wdata = {8{$urandom()}}; m0_wstrb = $urandom();
      run_burst(2'b01, 0, 1, 0, lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
      model_last = 0;
      tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL single_latency: got %0d want 1", lat); end
      tests_run++; if (id !== 4'd0 || g !== 2'b01) begin tests_failed++; $display("FAIL single_id_grant: got %0d/%b want 0/01", id, g); end
      tests_run++; if (a !== 28'h0000100 || len !== 4'd0) begin tests_failed++; $display("FAIL single_addr: got %h/%0d want 0000100/0", a, len); end
      tests_run++; if (awr !== 1) begin tests_failed++; $display("FAIL single_awready_pulses: got %0d want 1", awr); end
      tests_run++; if (wd !== m0_wdata || ws !== m0_wstrb) begin tests_failed++; $display("FAIL single_wdata: got %h want %h", wd, m0_wdata); end
      tests_run++; if (done !== 1'b1 || to !== 1'b0) begin tests_failed++; $display("FAIL single_return_idle: got done=%b timeout=%b want 1/0", done, to); end
      tick();
   endtask

   task automatic test_round_robin();
      int lat, unst, awr, leak, w; logic [1:0] g, wr, wl; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      apply_reset();
      for (int k = 0; k < 4; k++) begin
         m0_awaddr = $urandom(); m1_awaddr = $urandom(); m0_awlen = $urandom(); m1_awlen = $urandom();
         w = model_pick(2'b11);
         run_burst(2'b11, $urandom_range(0, 2), $urandom_range(1, 3), 0,
                   lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
         tests_run++; if (g !== 2'(1 << w) || id !== 4'(w)) begin tests_failed++; $display("FAIL rr_grant_%0d: got %b/%0d want requester %0d", k, g, id, w); end
         tests_run++; if (a !== (w ? m1_awaddr : m0_awaddr) || len !== (w ? m1_awlen : m0_awlen)) begin tests_failed++; $display("FAIL rr_addr_%0d: got %h want %h", k, a, w ? m1_awaddr : m0_awaddr); end
         model_last = w;
         tick();
      end
   endtask

   task automatic test_aw_stall();
      int lat, unst, awr, leak; logic [1:0] g, wr, wl; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      m1_awaddr = $urandom(); m1_awlen = $urandom();
      run_burst(2'b10, 10, 2, 0, lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
      model_last = 1;
      tests_run++; if (unst !== 0) begin tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles want 0", unst); end
      tests_run++; if (awr !== 1) begin tests_failed++; $display("FAIL stall_awready_pulses: got %0d want 1", awr); end
      tests_run++; if (a !== m1_awaddr || id !== 4'd1) begin tests_failed++; $display("FAIL stall_addr: got %h/%0d want %h/1", a, id, m1_awaddr); end
      tick();
   endtask

   task automatic test_wdata_mux();
      int lat, unst, awr, leak; logic [1:0] g, wr, wl; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      m1_wdata = {32{8'hA5}}; m0_wdata = {32{8'h5A}};
      m1_wstrb = $urandom(); m0_wstrb = ~m1_wstrb;
      run_burst(2'b10, 1, 4, 0, lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
      model_last = 1;
      tests_run++; if (wd !== {32{8'hA5}} || ws !== m1_wstrb) begin tests_failed++; $display("FAIL wmux_data: got %h want a5 pattern", wd); end
      tests_run++; if (leak !== 0) begin tests_failed++; $display("FAIL wmux_m0_wready: got %0d leaked cycles want 0", leak); end
      tests_run++; if (wr !== 2'b10 || wl !== 2'b10) begin tests_failed++; $display("FAIL wmux_ready_last: got %b/%b want 10/10", wr, wl); end
      tick();
   endtask

   task automatic test_arb_en();
      int lat, unst, awr, leak, spurious; logic [1:0] g, wr, wl; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      m0_awaddr = $urandom();
      run_burst(2'b01, 0, 3, 1, lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
      model_last = 0;
      tests_run++; if (done !== 1'b1 || to !== 1'b0) begin tests_failed++; $display("FAIL en_burst_completes: got done=%b timeout=%b want 1/0", done, to); end
      tick();
      m0_awvalid = 1; spurious = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge ddr_clk); if (ddr_axi_awvalid || arb_busy) spurious++;
         tick();
      end
      tests_run++; if (spurious !== 0) begin tests_failed++; $display("FAIL en_no_grant: got %0d grant cycles want 0", spurious); end
      arb_en = 1;
      @(negedge ddr_clk);
      tests_run++; if (ddr_axi_awvalid !== 1'b0) begin tests_failed++; $display("FAIL en_same_cycle: got %b want 0", ddr_axi_awvalid); end
      tick(); @(negedge ddr_clk);
      tests_run++; if (ddr_axi_awvalid !== 1'b1 || arb_grant !== 2'b01) begin tests_failed++; $display("FAIL en_grant_after_1: got %b/%b want 1/01", ddr_axi_awvalid, arb_grant); end
      ddr_axi_awready = 1; tick();
      ddr_axi_awready = 0; m0_awvalid = 0; ddr_axi_wready = 1; ddr_axi_wusero_last = 1; tick();
      ddr_axi_wready = 0; ddr_axi_wusero_last = 0; model_last = 0;
      @(negedge ddr_clk);
      tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("FAIL en_final_idle: got %b want 0", arb_busy); end
      tick();
   endtask

   task automatic test_reset_mid_burst();
      m1_awvalid = 1; tick(); tick();
      ddr_rst = 1; m1_awvalid = 0; tick(); ddr_rst = 0;
      @(negedge ddr_clk);
      tests_run++; if (arb_busy !== 1'b0 || ddr_axi_awvalid !== 1'b0 || arb_grant !== 2'b00) begin tests_failed++; $display("FAIL midreset_abandon: got busy=%b awvalid=%b grant=%b want 0/0/00", arb_busy, ddr_axi_awvalid, arb_grant); end
      model_last = 1;
      tick();
   endtask

   task automatic test_random();
      int lat, unst, awr, leak, w; logic [1:0] g, wr, wl, req; logic [3:0] id, len;
      logic [AW-1:0] a; logic [DW-1:0] wd; logic [SW-1:0] ws; logic done, to;
      for (int k = 0; k < 10; k++) begin
         req = 2'($urandom_range(1, 3));
         m0_awaddr = $urandom(); m1_awaddr = $urandom(); m0_awlen = $urandom(); m1_awlen = $urandom();
         m0_wdata = {8{$urandom()}}; m1_wdata = {8{$urandom()}}; m0_wstrb = $urandom(); m1_wstrb = $urandom();
         w = model_pick(req);
         run_burst(req, $urandom_range(0, 3), $urandom_range(1, 4), 0,
                   lat, g, id, a, len, unst, awr, wd, ws, wr, wl, leak, done, to);
         tests_run++; if (g !== 2'(1 << w) || id !== 4'(w) || lat !== 1) begin tests_failed++; $display("FAIL rand_grant_%0d: req=%b got %b/%0d lat %0d want requester %0d lat 1", k, req, g, id, lat, w); end
         tests_run++; if (a !== (w ? m1_awaddr : m0_awaddr) || len !== (w ? m1_awlen : m0_awlen)) begin tests_failed++; $display("FAIL rand_addr_%0d: got %h want %h", k, a, w ? m1_awaddr : m0_awaddr); end
         tests_run++; if (wd !== (w ? m1_wdata : m0_wdata) || ws !== (w ? m1_wstrb : m0_wstrb)) begin tests_failed++; $display("FAIL rand_wdata_%0d: got %h want %h", k, wd, w ? m1_wdata : m0_wdata); end
         tests_run++; if (awr !== 1 || leak !== 0 || unst !== 0 || done !== 1'b1 || to !== 1'b0) begin tests_failed++; $display("FAIL rand_protocol_%0d: got awr=%0d leak=%0d unst=%0d done=%b to=%b want 1/0/0/1/0", k, awr, leak, unst, done, to); end
         model_last = w;
         tick();
      end
   endtask

   task automatic test_wdog();
`ifdef DDR_WR_ARB_WDOG_EN
      int wd_cycles;
      m0_awvalid = 1; tick();
      ddr_axi_awready = 1; tick();
      ddr_axi_awready = 0; m0_awvalid = 0;
      wd_cycles = 0;
      @(negedge ddr_clk);
      while (arb_busy && wd_cycles < 40) begin
         wd_cycles++; tick(); @(negedge ddr_clk);
      end
      tests_run++; if (wd_cycles !== 16) begin tests_failed++; $display("FAIL wdog_cycles: got %0d want 16", wd_cycles); end
      tests_run++; if (wdog_err !== 1'b1 || arb_grant !== 2'b00) begin tests_failed++; $display("FAIL wdog_set: got err=%b grant=%b want 1/00", wdog_err, arb_grant); end
      tick(); wdog_clr = 1; tick(); wdog_clr = 0;
      @(negedge ddr_clk);
      tests_run++; if (wdog_err !== 1'b0) begin tests_failed++; $display("FAIL wdog_clear: got %b want 0", wdog_err); end
      model_last = 0;
`else
      wdog_clr = 1; tick(); wdog_clr = 0;
      @(negedge ddr_clk);
      tests_run++; if (wdog_err !== 1'b0) begin tests_failed++; $display("FAIL wdog_tied: got %b want 0", wdog_err); end
`endif
      tick();
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      idle_inputs(); ddr_rst = 1; arb_en = 1;
      m0_awaddr = 0; m1_awaddr = 0; m0_awlen = 0; m1_awlen = 0;
      m0_wdata = 0; m1_wdata = 0; m0_wstrb = 0; m1_wstrb = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_aw_stall();
      test_wdata_mux();
      test_arb_en();
      test_reset_mid_burst();
      test_random();
      test_wdog();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/ddr_wr_arbiter.md
DDR_WR_ARBITER -- requirements
Module: ddr_wr_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 28, DDR AXI byte address width.
REQ-002 Parameter: DATA_W, default 256, DDR AXI write data width; strobe width is DATA_W/8.
REQ-003 Parameter: WDOG_LIMIT, default 4096, watchdog cycle limit (only used when DDR_WR_ARB_WDOG_EN is defined).
REQ-004 ddr_clk  in  1  sole clock; one clock; reset is synchronous and active-high.
REQ-005 ddr_rst  in  1  synchronous active-high reset.
REQ-006 arb_en  in  1  when 1, new grants are allowed; when 0, no new grant is issued and an in-flight burst completes.
REQ-007 mN_awaddr / mN_awlen / mN_awvalid  in  ADDR_W/4/1  write-address request from requester N (N=0,1).
REQ-008 mN_awready  out  1  address accepted for requester N.
REQ-009 mN_wdata / mN_wstrb  in  DATA_W/DATA_W/8  write data from requester N.
REQ-010 mN_wready / mN_wlast  out  1/1  forwarded ddr_axi_wready / ddr_axi_wusero_last, gated to the granted requester.
REQ-011 ddr_axi_awaddr / ddr_axi_awuser_id / ddr_axi_awlen / ddr_axi_awvalid  out  ADDR_W/4/4/1  DDR write-address channel.
REQ-012 ddr_axi_awready  in  1  DDR address accept.
REQ-013 ddr_axi_wdata / ddr_axi_wstrb  out  DATA_W/DATA_W/8  DDR write data.
REQ-014 ddr_axi_wready / ddr_axi_wusero_last  in  1/1  DDR data pull and last-beat indication.
REQ-015 arb_busy / arb_grant  out  1/2  burst in flight; one-hot grant (bit N = requester N).
REQ-016 wdog_err  out  1  sticky watchdog error; wdog_clr  in  1  clears it.

Function
REQ-017 The FSM SHALL have three states: IDLE, AW, WD.
REQ-018 IDLE: if arb_en=1 and any mN_awvalid=1, the FSM SHALL select one requester, register its awaddr/awlen into ddr_axi_awaddr/awlen, set ddr_axi_awuser_id=N, set ddr_axi_awvalid=1 and arb_grant, and go to AW on the next edge (1-cycle request-to-awvalid latency).
REQ-019 Selection SHALL be round-robin: on a tie, the requester not granted last wins; a single requester wins unconditionally.
REQ-020 AW: ddr_axi_awvalid and ddr_axi_awaddr/awlen/awuser_id SHALL hold stable until ddr_axi_awready=1; in that cycle mN_awready (granted N only) SHALL be 1 combinationally, ddr_axi_awvalid SHALL clear at the edge, and the FSM SHALL go to WD.
REQ-021 The granted requester SHALL keep mN_awvalid high until mN_awready; a withdrawal during AW SHALL be ignored.
REQ-022 WD: ddr_axi_wdata/wstrb SHALL be combinationally muxed from the granted requester; mN_wready/mN_wlast SHALL follow ddr inputs for the granted requester and be 0 for the other.
REQ-023 WD exits to IDLE on ddr_axi_wready & ddr_axi_wusero_last; the last-grant pointer updates and arb_grant clears at that edge.
REQ-024 At least one IDLE cycle SHALL occur between bursts.
REQ-025 Outside WD, ddr_axi_wdata/wstrb SHALL be 0 and every mN_wready/mN_wlast SHALL be 0.
REQ-026 arb_busy SHALL be 1 in AW and WD, and 0 in IDLE.
REQ-027 Deasserting arb_en in AW or WD SHALL NOT abort the burst.

Reset
REQ-028 On ddr_rst=1 at an edge: state=IDLE, ddr_axi_awvalid=0, awaddr/awlen/awuser_id=0, arb_grant=0, last-grant pointer=1 (requester 0 wins the first tie), wdog_err=0, watchdog count=0.
REQ-029 Reset mid-burst SHALL abandon the burst immediately; there is no drain.

Configuration
REQ-030 With DDR_WR_ARB_WDOG_EN defined, a counter SHALL count cycles in WD, reset on each ddr_axi_wready beat; on reaching WDOG_LIMIT the FSM SHALL force IDLE, release the grant, and set wdog_err until wdog_clr=1 or reset.
REQ-031 Without DDR_WR_ARB_WDOG_EN, wdog_err SHALL be tied 0, wdog_clr SHALL be ignored, and no counter SHALL be synthesized.

Structure
REQ-032 A shared package ddr_arb_pkg SHALL hold the FSM state encoding, requester-count constant (2), and default ADDR_W/DATA_W.
REQ-033 The round-robin selector SHALL be one sub-module, rr_arb2 (inputs req[1:0] and last pointer; output one-hot grant).

Verification
REQ-034 Single request: m0 awaddr=0x0000100, awlen=0 -> ddr_axi_awvalid=1 one cycle later with awuser_id=0; m0_awready pulses with ddr_axi_awready; returns to IDLE after wready&wusero_last.
REQ-035 Simultaneous m0/m1 requests for 4 consecutive bursts -> grant order 0,1,0,1; awaddr matches the granted requester each time.
REQ-036 ddr_axi_awready held 0 for 10 cycles -> awvalid/awaddr stable for all 10 cycles, then exactly one awready pulse.
REQ-037 Write data: m1 granted with mN_wdata=0xA5 pattern and m0_wdata=0x5A -> ddr_axi_wdata=0xA5 pattern; m0_wready stays 0 throughout.
REQ-038 arb_en cleared during WD -> burst completes, then no grant issues while m0_awvalid=1; a grant issues 1 cycle after arb_en=1.
REQ-039 With DDR_WR_ARB_WDOG_EN defined and WDOG_LIMIT=16, wusero_last withheld -> IDLE after 16 cycles in WD and wdog_err=1; wdog_clr -> wdog_err=0.
